sti_frame_loader: RTL and testbench

- Writer-side counterpart of the distance-transform engine.
- Accepts a raster-order 1-bit pixel stream over a valid/ready handshake.
- Packs every 16 pixels into one word and writes it to the sti memory; col 0 of each group goes in bit 15, so the reader fetches pixel c at bit 15-c[3:0].
- In parallel, seeds the res memory with one byte per pixel (0 background, 1 object), so the DT engine can start on a fully loaded frame.

---
 rtl/sti_pkg.sv | 16 +
 rtl/sti_bit_packer.sv | 32 +++
 rtl/sti_frame_loader.sv | 107 ++++++++++
 tb/tb_sti_frame_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// sti_pkg: frame geometry, address widths, loader states and pixel coordinates
package sti_pkg;
    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int WORD_W = 16;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int WB     = $clog2(WORD_W);
    localparam int STI_AW = ROW_W + COL_W - WB;
    localparam int RES_AW = ROW_W + COL_W;
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } pix_coord_t;
endpackage

// File: rtl/sti_bit_packer.sv
// sti_bit_packer: shifts pixels MSB-first into a word and flags the 16th pixel
module sti_bit_packer
    import sti_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift,
    input  logic              din,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [WB-1:0]     cnt_q, cnt_d;
    assign word      = {sr_q[WORD_W-2:0], din};
    assign word_done = shift && (&cnt_q);
    // next shift register and fill count; clear wins over shift
    always_comb begin
        sr_d  = clr ? '0 : shift ? word : sr_q;
        cnt_d = clr ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    end
    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sti_frame_loader.sv
// sti_frame_loader: packs a raster pixel stream into sti words and seeds res bytes
// Optional BORDER_CLEAR_EN forces the outermost frame ring to 0 before writing.
module sti_frame_loader
    import sti_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pix_valid,
    input  logic              pix_in,
    output logic              pix_ready,
    output logic              sti_wr,
    output logic [STI_AW-1:0] sti_addr,
    output logic [WORD_W-1:0] sti_do,
    output logic              res_wr,
    output logic [RES_AW-1:0] res_addr,
    output logic [7:0]        res_do,
    output logic              busy,
    output logic              done
);
    state_t            state_q, state_d;
    pix_coord_t        pos_q, pos_d;
    logic              sti_wr_q, sti_wr_d, res_wr_q, res_wr_d;
    logic [STI_AW-1:0] sti_addr_q, sti_addr_d;
    logic [WORD_W-1:0] sti_do_q, sti_do_d;
    logic [RES_AW-1:0] res_addr_q, res_addr_d;
    logic [7:0]        res_do_q, res_do_d;
    logic              accept, last, clr, pix_eff, word_done;
    logic [WORD_W-1:0] word;
    assign pix_ready = state_q == LOAD;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign accept    = pix_valid && pix_ready;
    assign last      = pos_q.row == ROW_W'(IMG_H-1) && pos_q.col == COL_W'(IMG_W-1);
`ifdef BORDER_CLEAR_EN
    assign pix_eff = pix_in && !(pos_q.row == '0 || pos_q.row == ROW_W'(IMG_H-1) ||
                                 pos_q.col == '0 || pos_q.col == COL_W'(IMG_W-1));
`else
    assign pix_eff = pix_in;
`endif
    sti_bit_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .shift     (accept),
        .din       (pix_eff),
        .word      (word),
        .word_done (word_done)
    );
    // FSM and raster counters; the write registers drain during the single FLUSH cycle
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                pos_d   = '0;
                clr     = 1'b1;
            end
            LOAD: if (accept) begin
                pos_d.col = pos_q.col + 1'b1;
                pos_d.row = pos_q.col == COL_W'(IMG_W-1) ? pos_q.row + 1'b1 : pos_q.row;
                state_d   = last ? FLUSH : LOAD;
            end
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    // memory write ports: strobes follow the accept by one cycle, address/data hold otherwise
    always_comb begin
        res_wr_d   = accept;
        res_addr_d = accept ? {pos_q.row, pos_q.col} : res_addr_q;
        res_do_d   = accept ? {7'b0, pix_eff} : res_do_q;
        sti_wr_d   = word_done;
        sti_addr_d = word_done ? {pos_q.row, pos_q.col[COL_W-1:WB]} : sti_addr_q;
        sti_do_d   = word_done ? word : sti_do_q;
    end
    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            sti_wr_q   <= 1'b0;
            sti_addr_q <= '0;
            sti_do_q   <= '0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            sti_wr_q   <= sti_wr_d;
            sti_addr_q <= sti_addr_d;
            sti_do_q   <= sti_do_d;
            res_wr_q   <= res_wr_d;
            res_addr_q <= res_addr_d;
            res_do_q   <= res_do_d;
        end
    end
    assign sti_wr   = sti_wr_q;
    assign sti_addr = sti_addr_q;
    assign sti_do   = sti_do_q;
    assign res_wr   = res_wr_q;
    assign res_addr = res_addr_q;
    assign res_do   = res_do_q;
endmodule

// File: tb/tb_sti_frame_loader.sv
// tb_sti_frame_loader: scoreboard bench for the sti/res frame loader
module tb_sti_frame_loader;
    logic        clk = 0, reset = 0, start = 0, pix_valid = 0, pix_in = 0;
    logic        pix_ready, sti_wr, res_wr, busy, done;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;
    logic [13:0] res_addr;
    logic [7:0]  res_do;

    sti_frame_loader dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
        .pix_ready(pix_ready), .sti_wr(sti_wr), .sti_addr(sti_addr), .sti_do(sti_do),
        .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [25:0] sti_q[$];
    logic [21:0] res_q[$];
    logic [25:0] sexp;
    logic [21:0] rexp;
    logic [15:0] sti_mem[1024], sti_ref[1024];
    logic [7:0]  res_mem[16384], res_ref[16384];
    int          sti_cnt = 0, res_cnt = 0, done_cnt = 0, first_sti = -1;
    logic [15:0] mw;

    // monitor: pop expectations on every write strobe, mirror memories, count events
    always @(negedge clk) begin
        if (res_wr) begin
            if (res_q.size() == 0) check("res_unexpected", 1, 0);
            else begin
                rexp = res_q.pop_front();
                check("res_addr", 32'(res_addr), 32'(rexp[21:8]));
                check("res_do", 32'(res_do), 32'(rexp[7:0]));
            end
            check("sti_coincide", 32'(sti_wr), 32'(res_addr[3:0] == 4'hf));
            res_mem[res_addr] = res_do;
            res_cnt++;
        end
        if (sti_wr) begin
            if (sti_q.size() == 0) check("sti_unexpected", 1, 0);
            else begin
                sexp = sti_q.pop_front();
                check("sti_addr", 32'(sti_addr), 32'(sexp[25:16]));
                check("sti_do", 32'(sti_do), 32'(sexp[15:0]));
            end
            if (sti_cnt == 0) first_sti = int'(sti_addr);
            sti_mem[sti_addr] = sti_do;
            sti_cnt++;
        end
        if (done) done_cnt++;
    end

    initial begin
        #1500000;
        check("watchdog", 1, 0);
        $fatal(1, "FAIL watchdog expired");
    end

    function automatic logic pix_of(input int mode, input int r, input int c);
        case (mode)
            0:       return r == 3 && c == 17;
            1:       return ((r * 128 + c) % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic send_pixel(input int r, input int c, input logic p);
        logic e;
        int   t;
`ifdef BORDER_CLEAR_EN
        e = p && !(r == 0 || r == 127 || c == 0 || c == 127);
`else
        e = p;
`endif
        pix_valid = 1;
        pix_in    = p;
        t = 0;
        while (!pix_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            check("ready_timeout", 0, 1);
            $fatal(1, "FAIL ready_timeout");
        end
        mw = {mw[14:0], e};
        res_q.push_back({14'(r * 128 + c), 7'b0, e});
        if (c % 16 == 15) sti_q.push_back({10'(r * 8 + c / 16), mw});
        @(negedge clk);
        pix_valid = 0;
    endtask

    task automatic run_frame(input int mode, input bit stall, input bit mid);
        int t;
        sti_cnt = 0; res_cnt = 0; done_cnt = 0; first_sti = -1; mw = '0;
        start = 1;
        @(negedge clk);
        start = 0;
        check("busy_start", 32'(busy), 1);
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++) begin
                if (stall && $urandom_range(0, 7) == 0) repeat ($urandom_range(0, 5)) @(negedge clk);
                if (mid && r == 64 && c == 0) start = 1;
                send_pixel(r, c, pix_of(mode, r, c));
                start = 0;
            end
        t = 0;
        while (!done && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(done), 1);
        @(negedge clk);
        check("busy_end", 32'(busy), 0);
        check("done_once", 32'(done_cnt), 1);
        check("sti_total", 32'(sti_cnt), 1024);
        check("res_total", 32'(res_cnt), 16384);
        check("sb_empty", 32'(sti_q.size() + res_q.size()), 0);
        check("first_sti_addr", 32'(first_sti), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"}, 32'(pix_ready), 0);
        check({tag, "_sti_wr"}, 32'(sti_wr), 0);
        check({tag, "_sti_addr"}, 32'(sti_addr), 0);
        check({tag, "_sti_do"}, 32'(sti_do), 0);
        check({tag, "_res_wr"}, 32'(res_wr), 0);
        check({tag, "_res_addr"}, 32'(res_addr), 0);
        check({tag, "_res_do"}, 32'(res_do), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    int n;
    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1;
        @(negedge clk);

        // partial frame abandoned by reset mid-LOAD
        sti_cnt = 0; res_cnt = 0; mw = '0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 40; c++) send_pixel(0, c, logic'(c % 2));
        pix_valid = 1;
        #2;
        check("partial_sti", 32'(sti_cnt), 2);
        check("partial_res", 32'(res_cnt), 40);
        check("partial_sb_empty", 32'(sti_q.size() + res_q.size()), 0);
        reset = 0;
        #1;
        check_reset_outputs("midrst");
        sti_q.delete();
        res_q.delete();
        @(negedge clk);
        reset = 1;
        sti_cnt = 0; res_cnt = 0;
        repeat (20) @(negedge clk);
        check("idle_no_sti", 32'(sti_cnt), 0);
        check("idle_no_res", 32'(res_cnt), 0);
        check("idle_busy", 32'(busy), 0);
        pix_valid = 0;

        // single object pixel at (3,17)
        run_frame(0, 0, 0);
        check("sparse_res_3_17", 32'(res_mem[3 * 128 + 17]), 1);
        n = 0;
        for (int i = 0; i < 16384; i++) n += (res_mem[i] != 0) ? 1 : 0;
        check("sparse_res_ones", 32'(n), 1);
        check("sparse_word25", 32'(sti_mem[25]), 32'h4000);
        n = 0;
        for (int i = 0; i < 1024; i++) n += (sti_mem[i] != 0) ? 1 : 0;
        check("sparse_words_nz", 32'(n), 1);

        // alternating 1,0,... with no stalls; second start restarts at (0,0)
        run_frame(1, 0, 0);
        n = 0;
        for (int r = 1; r < 127; r++)
            for (int w = 1; w < 7; w++) n += (sti_mem[r * 8 + w] != 16'hAAAA) ? 1 : 0;
        check("alt_words", 32'(n), 0);
`ifndef BORDER_CLEAR_EN
        check("alt_word0", 32'(sti_mem[0]), 32'hAAAA);
`endif
        for (int i = 0; i < 1024; i++) sti_ref[i] = sti_mem[i];
        for (int i = 0; i < 16384; i++) res_ref[i] = res_mem[i];

        // same pattern with random stalls and an ignored mid-frame start
        for (int i = 0; i < 1024; i++) sti_mem[i] = 16'h5A5A;
        for (int i = 0; i < 16384; i++) res_mem[i] = 8'h5A;
        run_frame(1, 1, 1);
        n = 0;
        for (int i = 0; i < 1024; i++) n += (sti_mem[i] != sti_ref[i]) ? 1 : 0;
        for (int i = 0; i < 16384; i++) n += (res_mem[i] != res_ref[i]) ? 1 : 0;
        check("stall_image", 32'(n), 0);

        // all-ones frame
        run_frame(2, 0, 0);
`ifdef BORDER_CLEAR_EN
        check("ones_word0", 32'(sti_mem[0]), 32'h0000);
        check("ones_word8", 32'(sti_mem[8]), 32'h7FFF);
        check("ones_word15", 32'(sti_mem[15]), 32'hFFFE);
        n = 0;
        for (int c = 0; c < 128; c++) n += (res_mem[c] != 0) ? 1 : 0;
        check("ones_res_row0", 32'(n), 0);
        check("ones_res_5_5", 32'(res_mem[5 * 128 + 5]), 1);
`else
        n = 0;
        for (int i = 0; i < 1024; i++) n += (sti_mem[i] != 16'hFFFF) ? 1 : 0;
        check("ones_words", 32'(n), 0);
        check("ones_res_0_0", 32'(res_mem[0]), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
